// File: rtl/memory_stage.sv
// memory_stage: MEM stage of the 5-stage MIPS pipeline.
// Performs the data-memory access over a req/ack handshake with wait states
// and a timeout. Drives the branch redirect and the upstream stall, and loads
// the MEM/WB pipeline register consumed by write-back.
// Optional feature: define MEM_ALIGN_CHECK_EN to reject word accesses whose
// address is not 4-byte aligned (no request issued, sticky bus_error raised).
module memory_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] alu_result,
  input  logic        zero,
  input  logic [31:0] branch_or_not_address,
  input  logic [4:0]  write_register,
  input  logic [31:0] store_data,
  input  logic        ctrl_memRead,
  input  logic        ctrl_memWrite,
  input  logic        ctrl_branch,
  input  logic        ctrl_regWrite,
  input  logic        ctrl_memToReg,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall,
  output logic        pc_src,
  output logic [31:0] branch_target,
  output logic        valid_mem_wb,
  output logic        ctrl_regWrite_mem_wb,
  output logic        ctrl_memToReg_mem_wb,
  output logic [31:0] read_data_mem_wb,
  output logic [31:0] alu_result_mem_wb,
  output logic [4:0]  write_register_mem_wb,
  output logic        bus_error
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } memState_t;

  // Last wait-counter value before the access is abandoned.
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

  memState_t   state_q, state_d;
  logic [7:0]  waitCnt_q, waitCnt_d;
  logic        busError_q, busError_d;

  logic        wbValid_q, wbValid_d;
  logic        wbRegWrite_q, wbRegWrite_d;
  logic        wbMemToReg_q, wbMemToReg_d;
  logic [31:0] wbReadData_q, wbReadData_d;
  logic [31:0] wbAluResult_q, wbAluResult_d;
  logic [4:0]  wbWriteReg_q, wbWriteReg_d;

  logic memOp;
  logic misaligned;
  logic accessOp;
  logic timeout;
  logic complete;
  logic accept;
  logic isLoad;

  assign memOp = in_valid & (ctrl_memRead | ctrl_memWrite);

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = memOp & (alu_result[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // A misaligned operation never reaches the bus; everything else that is a
  // memory op does.
  assign accessOp = memOp & ~misaligned;
  assign complete = accessOp & dmem_ack;
  assign isLoad   = ctrl_memRead & ~ctrl_memWrite;

  // The instruction leaves the stage when it needs no memory or its ack is here.
  assign accept = in_valid & (~memOp | complete);

  // Next-state logic for the handshake FSM and its wait counter; flags timeout.
  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    timeout   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accessOp && !dmem_ack) begin
          state_d   = WAIT;
          waitCnt_d = 8'd0;
        end
      end
      WAIT: begin
        if (dmem_ack) begin
          state_d = IDLE;
        end else if (waitCnt_q == TimeoutLast) begin
          timeout = 1'b1;
          state_d = IDLE;
        end else begin
          waitCnt_d = waitCnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus, stall and redirect outputs; reset forces the handshake quiet at once.
  always_comb begin
    dmem_req      = 1'b0;
    stall         = 1'b0;
    pc_src        = 1'b0;
    dmem_we       = ctrl_memWrite;
    dmem_addr     = alu_result;
    dmem_wdata    = store_data;
    branch_target = branch_or_not_address;
    if (!reset) begin
      dmem_req = (state_q == IDLE) ? accessOp : ~timeout;
      stall    = accessOp & ~dmem_ack & ~timeout;
      pc_src   = in_valid & ctrl_branch & zero & ~(accessOp & ~dmem_ack & ~timeout);
    end
  end

  // Next MEM/WB contents: a real instruction or a bubble that keeps the data.
  always_comb begin
    wbValid_d     = accept;
    wbRegWrite_d  = accept & ctrl_regWrite;
    wbMemToReg_d  = accept & ctrl_memToReg;
    wbReadData_d  = wbReadData_q;
    wbAluResult_d = wbAluResult_q;
    wbWriteReg_d  = wbWriteReg_q;
    if (accept) begin
      wbAluResult_d = alu_result;
      wbWriteReg_d  = write_register;
      if (isLoad) begin
        wbReadData_d = dmem_rdata;
      end
    end
    busError_d = busError_q | timeout | misaligned;
  end

  // FSM state and wait counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      waitCnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
    end
  end

  // MEM/WB pipeline register and the sticky bus error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wbValid_q     <= 1'b0;
      wbRegWrite_q  <= 1'b0;
      wbMemToReg_q  <= 1'b0;
      wbReadData_q  <= 32'd0;
      wbAluResult_q <= 32'd0;
      wbWriteReg_q  <= 5'd0;
      busError_q    <= 1'b0;
    end else begin
      wbValid_q     <= wbValid_d;
      wbRegWrite_q  <= wbRegWrite_d;
      wbMemToReg_q  <= wbMemToReg_d;
      wbReadData_q  <= wbReadData_d;
      wbAluResult_q <= wbAluResult_d;
      wbWriteReg_q  <= wbWriteReg_d;
      busError_q    <= busError_d;
    end
  end

  assign valid_mem_wb          = wbValid_q;
  assign ctrl_regWrite_mem_wb  = wbRegWrite_q;
  assign ctrl_memToReg_mem_wb  = wbMemToReg_q;
  assign read_data_mem_wb      = wbReadData_q;
  assign alu_result_mem_wb     = wbAluResult_q;
  assign write_register_mem_wb = wbWriteReg_q;
  assign bus_error             = busError_q;

endmodule

// File: doc/memory_stage.md
# memory_stage

MEM stage of the 5-stage MIPS pipeline. Consumes the registered outputs of the execute stage (ALU result, zero flag, branch target, destination register, store data, control bits) and performs the data-memory access over a req/ack handshake with wait states and a timeout. Produces the branch redirect for fetch and a stall for upstream stages, and loads the MEM/WB pipeline register consumed by write-back.

## Interface
- `TIMEOUT_CYCLES`, 16: WAIT cycles without `dmem_ack` before the access is abandoned (range 1..255).
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `in_valid` in 1: execute-stage outputs hold a real instruction.
- `alu_result` in 32: data address for loads/stores, or the result to forward.
- `zero` in 1: branch-equal flag.
- `branch_or_not_address` in 32: branch target.
- `write_register` in 5: destination register.
- `store_data` in 32: rt value for stores.
- `ctrl_memRead`, `ctrl_memWrite`, `ctrl_branch`, `ctrl_regWrite`, `ctrl_memToReg` in 1 each: control bits carried from decode.
- `dmem_req` out 1: access request.
- `dmem_we` out 1: 1 = store.
- `dmem_addr` out 32: access address.
- `dmem_wdata` out 32: store data.
- `dmem_rdata` in 32: load data; valid when `dmem_ack` = 1.
- `dmem_ack` in 1: access complete.
- `stall` out 1: upstream must hold all inputs unchanged.
- `pc_src` out 1: take branch.
- `branch_target` out 32: redirect address.
- `valid_mem_wb`, `ctrl_regWrite_mem_wb`, `ctrl_memToReg_mem_wb` out 1 each: MEM/WB control bits.
- `read_data_mem_wb`, `alu_result_mem_wb` out 32: MEM/WB data.
- `write_register_mem_wb` out 5: MEM/WB destination register.
- `bus_error` out 1: sticky; set on timeout or misalignment; cleared only by reset.

## Operation
- `mem_op = in_valid & (ctrl_memRead | ctrl_memWrite)`. If both read and write are set, the write takes precedence (`dmem_we` = 1).
- FSM has two states, IDLE and WAIT.
- **IDLE**:
  - `dmem_req = mem_op`, combinationally.
  - If `mem_op & dmem_ack`, the access completes this cycle (zero-wait).
  - If `mem_op & !dmem_ack`, go to WAIT and clear the timeout counter.
- **WAIT**:
  - `dmem_req` = 1. Address, data and `we` are driven straight from the held inputs.
  - When `dmem_ack` = 1, the access completes and the FSM returns to IDLE.
  - The counter increments on every cycle without ack. If `dmem_ack` = 0 when the counter reaches `TIMEOUT_CYCLES`-1, that is a timeout: drop `req`, set `bus_error`, write a bubble to MEM/WB, deassert `stall`, return to IDLE. The counter is 8 bits.
- `stall = mem_op & !dmem_ack`, in both states. The instruction is released in the cycle its ack arrives. In the timeout cycle `stall` is forced to 0.
- MEM/WB register loads on every rising edge:
  - Completing access or non-memory valid instruction: `valid` = 1; the control bits, `alu_result` and `write_register` are copied from the inputs. On a load, `read_data` = `dmem_rdata`; otherwise `read_data` holds its previous value.
  - While stalled, on timeout, or when `in_valid` = 0: bubble. `valid`, `regWrite` and `memToReg` = 0; the data fields hold their previous values.
- Branch (combinational):
  - `pc_src = in_valid & ctrl_branch & zero & !stall`.
  - `branch_target = branch_or_not_address`.
- `dmem_ack` received in IDLE with `mem_op` = 0 is ignored.

## Timing
- Reset values:
  - All MEM/WB outputs = 0, `bus_error` = 0, FSM in IDLE, counter = 0.
  - `dmem_req`, `stall` and `pc_src` are 0 whenever `reset` is high, independent of the inputs.
- Latency: input to MEM/WB is 1 cycle for a non-memory instruction or a zero-wait access, and 1+N cycles for N wait cycles.
- Back-to-back memory ops with zero-wait ack sustain one per cycle.
- Handshake rules:
  - `req` stays high until ack or timeout, and is never withdrawn early.
  - Address, data and `we` are stable while `req` is high. This holds because upstream honours `stall`.
- Reset asserted in WAIT: `req` drops asynchronously and the access is lost. After reset, operation restarts in IDLE.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - A `mem_op` with `alu_result[1:0]` != 0 is misaligned. It issues no `dmem_req`, produces no stall, writes a bubble to MEM/WB and sets `bus_error` at the next edge.
- Undefined: no check; `dmem_addr` = `alu_result` is passed unmodified.

## Test plan
- Zero-wait load: `alu_result` = 0x100, `memRead` = 1, `memToReg` = 1, `ack` high in the same cycle with rdata 0xDEADBEEF → `stall` stays 0; next edge `read_data_mem_wb` = 0xDEADBEEF, `valid_mem_wb` = 1.
- Store with 3 wait cycles: addr 0x40, data 0x1234, ack in the 4th cycle → `req`/`we` high for 4 cycles with stable addr/data; `stall` high for 3 cycles; one MEM/WB with `valid` = 1, `regWrite` = 0 after ack; bubbles before it.
- Branch: `ctrl_branch` = 1, `zero` = 1, target 0x2000 → `pc_src` = 1, `branch_target` = 0x2000 in the same cycle. With `zero` = 0 → `pc_src` = 0.
- Timeout: load, ack never asserted, `TIMEOUT_CYCLES` = 4 → `req` high for 4 cycles, then drops; `bus_error` = 1; MEM/WB bubble; `stall` released.
- Reset mid-WAIT: assert `reset` in the 2nd wait cycle → `req`, `stall` and all outputs go to 0 immediately; after release, a new zero-wait load completes normally.
- With `MEM_ALIGN_CHECK_EN`: load at 0x102 → no `req`, `bus_error` = 1, bubble in MEM/WB. Without the macro: `req` issued with `dmem_addr` = 0x102.
